uart_fifo_wr: RTL and testbench

Write-side controller of the UART async FIFO, the counterpart of the read-side controller. It runs in the write clock domain and accepts write requests. It produces the memory write enable and write address. It advances the binary write pointer and publishes a Gray-coded copy for synchronisation into the read domain. It generates registered full and almost-full flags against the read pointer, which arrives already synchronised and converted back to binary.

---
 rtl/uart_fifo_pkg.sv | 13 +
 rtl/uart_fifo_bin2gray.sv | 17 +
 rtl/uart_fifo_wr.sv | 86 ++++++++
 tb/tb_uart_fifo_wr.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART async FIFO pointer controllers.
// Holds the default geometry and the binary-to-Gray helper used on both sides.
package uart_fifo_pkg;

  localparam int DEF_PTR_WIDTH = 4;
  localparam int DEF_AF_THRESH = 6;

  // Operates on a wide word so any pointer width up to 32 bits can reuse it.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/uart_fifo_bin2gray.sv
// Combinational binary-to-Gray converter for FIFO pointers.
// Shared by the write-side and read-side controllers.
module uart_fifo_bin2gray
  import uart_fifo_pkg::*;
#(
  parameter int PTR_WIDTH = DEF_PTR_WIDTH
) (
  input  logic [PTR_WIDTH-1:0] bin,
  output logic [PTR_WIDTH-1:0] gray
);

  logic [31:0] gray_wide;

  assign gray_wide = bin2gray(32'(bin));
  assign gray      = gray_wide[PTR_WIDTH-1:0];

endmodule

// File: rtl/uart_fifo_wr.sv
// Write-side pointer/flag controller of the UART async FIFO (write clock domain).
// Optional sticky overflow flag enabled by defining UART_FIFO_WR_OVF_EN.
module uart_fifo_wr
  import uart_fifo_pkg::*;
#(
  parameter int PTR_WIDTH = DEF_PTR_WIDTH,
  parameter int AF_THRESH = DEF_AF_THRESH
) (
`ifdef UART_FIFO_WR_OVF_EN
  input  logic                 i_fifo_wr_ovf_clr,
  output logic                 o_fifo_wr_overflow,
`endif
  input  logic                 i_fifo_wr_clk,
  input  logic                 i_fifo_wr_rst_n,
  input  logic                 i_fifo_wr_winc,
  input  logic [PTR_WIDTH-1:0] i_fifo_wr_rptr_conv,
  output logic [PTR_WIDTH-1:0] o_fifo_wr_wptr,
  output logic [PTR_WIDTH-1:0] o_fifo_wr_wptr_gray,
  output logic [PTR_WIDTH-2:0] o_fifo_wr_waddr,
  output logic                 o_fifo_wr_wen,
  output logic                 o_fifo_wr_full,
  output logic                 o_fifo_wr_almost_full,
  output logic [PTR_WIDTH-1:0] o_fifo_wr_level
);

  localparam logic [PTR_WIDTH-1:0] AF_LEVEL = PTR_WIDTH'(AF_THRESH);

  logic [PTR_WIDTH-1:0] wptr_next;
  logic [PTR_WIDTH-1:0] gray_next;
  logic [PTR_WIDTH-1:0] level_next;
  logic [PTR_WIDTH-1:0] rptr_full_match;
  logic                 full_next;
  logic                 af_next;

  // Handshake: winc is a request, ~full is the ready; a write is taken on
  // every rising edge where both are high (wen), and the memory stores on
  // that same edge at waddr. Requests while full are dropped, not queued.
  assign o_fifo_wr_wen   = i_fifo_wr_winc & ~o_fifo_wr_full & i_fifo_wr_rst_n;
  assign o_fifo_wr_waddr = o_fifo_wr_wptr[PTR_WIDTH-2:0];

  assign wptr_next  = o_fifo_wr_wptr + PTR_WIDTH'(o_fifo_wr_wen);
  assign level_next = wptr_next - i_fifo_wr_rptr_conv;

  // Full when the pointers address the same slot but differ in the wrap bit.
  assign rptr_full_match = {~i_fifo_wr_rptr_conv[PTR_WIDTH-1],
                            i_fifo_wr_rptr_conv[PTR_WIDTH-2:0]};
  assign full_next       = (wptr_next == rptr_full_match);
  assign af_next         = (level_next >= AF_LEVEL);

  uart_fifo_bin2gray #(
    .PTR_WIDTH(PTR_WIDTH)
  ) u_bin2gray (
    .bin  (wptr_next),
    .gray (gray_next)
  );

  always_ff @(posedge i_fifo_wr_clk) begin
    if (!i_fifo_wr_rst_n) begin
      o_fifo_wr_wptr        <= '0;
      o_fifo_wr_wptr_gray   <= '0;
      o_fifo_wr_full        <= 1'b0;
      o_fifo_wr_almost_full <= 1'b0;
      o_fifo_wr_level       <= '0;
    end else begin
      o_fifo_wr_wptr        <= wptr_next;
      o_fifo_wr_wptr_gray   <= gray_next;
      o_fifo_wr_full        <= full_next;
      o_fifo_wr_almost_full <= af_next;
      o_fifo_wr_level       <= level_next;
    end
  end

`ifdef UART_FIFO_WR_OVF_EN
  // Sticky; a rejected write in the same cycle as a clear keeps it set.
  always_ff @(posedge i_fifo_wr_clk) begin
    if (!i_fifo_wr_rst_n) begin
      o_fifo_wr_overflow <= 1'b0;
    end else if (i_fifo_wr_winc && o_fifo_wr_full) begin
      o_fifo_wr_overflow <= 1'b1;
    end else if (i_fifo_wr_ovf_clr) begin
      o_fifo_wr_overflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_fifo_wr.sv
// Directed testbench for uart_fifo_wr (default geometry: PTR_WIDTH=4, AF_THRESH=6).
// Covers the overflow flag as well when UART_FIFO_WR_OVF_EN is defined.
module tb_uart_fifo_wr;

  localparam int PW = 4;

  logic          clk;
  logic          rst_n;
  logic          winc;
  logic [PW-1:0] rptr_conv;
  logic [PW-1:0] wptr;
  logic [PW-1:0] wptr_gray;
  logic [PW-2:0] waddr;
  logic          wen;
  logic          full;
  logic          almost_full;
  logic [PW-1:0] level;
`ifdef UART_FIFO_WR_OVF_EN
  logic          ovf_clr;
  logic          overflow;
`endif

  int checks   = 0;
  int failures = 0;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  uart_fifo_wr #(
    .PTR_WIDTH(4),
    .AF_THRESH(6)
  ) dut (
`ifdef UART_FIFO_WR_OVF_EN
    .i_fifo_wr_ovf_clr     (ovf_clr),
    .o_fifo_wr_overflow    (overflow),
`endif
    .i_fifo_wr_clk         (clk),
    .i_fifo_wr_rst_n       (rst_n),
    .i_fifo_wr_winc        (winc),
    .i_fifo_wr_rptr_conv   (rptr_conv),
    .o_fifo_wr_wptr        (wptr),
    .o_fifo_wr_wptr_gray   (wptr_gray),
    .o_fifo_wr_waddr       (waddr),
    .o_fifo_wr_wen         (wen),
    .o_fifo_wr_full        (full),
    .o_fifo_wr_almost_full (almost_full),
    .o_fifo_wr_level       (level)
  );

  // Driver: advance one edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; winc = 1'b0; rptr_conv = '0;
`ifdef UART_FIFO_WR_OVF_EN
    ovf_clr = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++; if (wptr !== 4'd0) begin failures++; $display("FAIL reset_wptr: actual=%0d required=0", wptr); end
    checks++; if (wptr_gray !== 4'd0) begin failures++; $display("FAIL reset_gray: actual=%b required=0000", wptr_gray); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full: actual=%b required=0", full); end
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_af: actual=%b required=0", almost_full); end
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level: actual=%0d required=0", level); end
    checks++; if (wen !== 1'b0) begin failures++; $display("FAIL reset_wen: actual=%b required=0", wen); end
`ifdef UART_FIFO_WR_OVF_EN
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: actual=%b required=0", overflow); end
`endif
    tick();
    checks++; if (wptr !== 4'd0) begin failures++; $display("FAIL idle_wptr: actual=%0d required=0", wptr); end
  endtask

  task automatic test_fill();
    logic exp_af;
    for (int i = 0; i < 8; i++) begin
      winc = 1'b1;
      #1;
      checks++; if (wen !== 1'b1) begin failures++; $display("FAIL fill_wen[%0d]: actual=%b required=1", i, wen); end
      checks++; if (waddr !== 3'(i)) begin failures++; $display("FAIL fill_waddr[%0d]: actual=%0d required=%0d", i, waddr, i); end
      tick();
      exp_af = (i + 1 >= 6);
      checks++; if (level !== 4'(i + 1)) begin failures++; $display("FAIL fill_level[%0d]: actual=%0d required=%0d", i, level, i + 1); end
      checks++; if (almost_full !== exp_af) begin failures++; $display("FAIL fill_af[%0d]: actual=%b required=%b", i, almost_full, exp_af); end
      checks++; if (full !== (i == 7)) begin failures++; $display("FAIL fill_full[%0d]: actual=%b required=%b", i, full, (i == 7)); end
    end
    checks++; if (wptr !== 4'b1000) begin failures++; $display("FAIL fill_wptr: actual=%b required=1000", wptr); end
    checks++; if (wptr_gray !== 4'b1100) begin failures++; $display("FAIL fill_gray: actual=%b required=1100", wptr_gray); end
  endtask

  task automatic test_write_full();
    winc = 1'b1;
    #1;
    checks++; if (wen !== 1'b0) begin failures++; $display("FAIL wfull_wen: actual=%b required=0", wen); end
    tick();
    winc = 1'b0;
    checks++; if (wptr !== 4'd8) begin failures++; $display("FAIL wfull_wptr: actual=%0d required=8", wptr); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL wfull_full: actual=%b required=1", full); end
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL wfull_level: actual=%0d required=8", level); end
`ifdef UART_FIFO_WR_OVF_EN
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: actual=%b required=1", overflow); end
    tick();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: actual=%b required=1", overflow); end
    // Clear coinciding with a rejected write: set must win.
    ovf_clr = 1'b1; winc = 1'b1;
    tick();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins: actual=%b required=1", overflow); end
    winc = 1'b0;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr: actual=%b required=0", overflow); end
`endif
  endtask

  task automatic test_read_progress();
    winc = 1'b0; rptr_conv = 4'd1;
    tick();
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL rd_full: actual=%b required=0", full); end
    checks++; if (level !== 4'd7) begin failures++; $display("FAIL rd_level: actual=%0d required=7", level); end
    checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL rd_af: actual=%b required=1", almost_full); end
    winc = 1'b1;
    #1;
    checks++; if (wen !== 1'b1) begin failures++; $display("FAIL rd_wen: actual=%b required=1", wen); end
    tick();
    winc = 1'b0;
    checks++; if (wptr !== 4'd9) begin failures++; $display("FAIL rd_wptr: actual=%0d required=9", wptr); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL rd_refull: actual=%b required=1", full); end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] exp_wptr;
    logic [PW-1:0] exp_gray;
    logic [PW-1:0] prev_gray;
    int            wraps;
    exp_wptr  = 4'd9;
    prev_gray = 4'b1101;
    wraps     = 0;
    rptr_conv = exp_wptr - 4'd2;
    tick();
    checks++; if (level !== 4'd2) begin failures++; $display("FAIL b2b_start_level: actual=%0d required=2", level); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL b2b_start_full: actual=%b required=0", full); end
    for (int i = 0; i < 40; i++) begin
      rptr_conv = exp_wptr - 4'd2;
      winc = 1'b1;
      #1;
      checks++; if (wen !== 1'b1) begin failures++; $display("FAIL b2b_wen[%0d]: actual=%b required=1", i, wen); end
      tick();
      if (exp_wptr == 4'd15) wraps++;
      exp_wptr = exp_wptr + 4'd1;
      exp_gray = exp_wptr ^ (exp_wptr >> 1);
      checks++; if (wptr !== exp_wptr) begin failures++; $display("FAIL b2b_wptr[%0d]: actual=%0d required=%0d", i, wptr, exp_wptr); end
      checks++; if (wptr_gray !== exp_gray) begin failures++; $display("FAIL b2b_gray[%0d]: actual=%b required=%b", i, wptr_gray, exp_gray); end
      checks++; if ($countones(wptr_gray ^ prev_gray) != 1) begin failures++; $display("FAIL b2b_gray_step[%0d]: actual=%b->%b required=one_bit_change", i, prev_gray, wptr_gray); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL b2b_full[%0d]: actual=%b required=0", i, full); end
      checks++; if (level !== 4'd3) begin failures++; $display("FAIL b2b_level[%0d]: actual=%0d required=3", i, level); end
      prev_gray = wptr_gray;
    end
    winc = 1'b0;
    checks++; if (wraps < 2) begin failures++; $display("FAIL b2b_wraps: actual=%0d required>=2", wraps); end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; winc = 1'b0; rptr_conv = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      winc = 1'b1;
      tick();
    end
    checks++; if (wptr !== 4'd5) begin failures++; $display("FAIL mid_pre_wptr: actual=%0d required=5", wptr); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL mid_pre_full: actual=%b required=0", full); end
    rst_n = 1'b0;
    #1;
    checks++; if (wen !== 1'b0) begin failures++; $display("FAIL mid_wen_in_reset: actual=%b required=0", wen); end
    tick();
    checks++; if (wptr !== 4'd0) begin failures++; $display("FAIL mid_wptr: actual=%0d required=0", wptr); end
    checks++; if (wptr_gray !== 4'd0) begin failures++; $display("FAIL mid_gray: actual=%b required=0000", wptr_gray); end
    checks++; if (almost_full !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL mid_flags: actual=%b%b required=00", full, almost_full); end
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL mid_level: actual=%0d required=0", level); end
    checks++; if (wen !== 1'b0) begin failures++; $display("FAIL mid_wen_held: actual=%b required=0", wen); end
    tick();
    checks++; if (wptr !== 4'd0) begin failures++; $display("FAIL mid_wptr_held: actual=%0d required=0", wptr); end
    rst_n = 1'b1;
    tick();
    winc = 1'b0;
    checks++; if (wptr !== 4'd1) begin failures++; $display("FAIL mid_release_wptr: actual=%0d required=1", wptr); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_full();
    test_read_progress();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
